stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter WIDTH, default 14, count/datapath width in bits.
REQ-002 Parameter MAX, default 9999, terminal count; SHALL satisfy MAX < 2**WIDTH.
REQ-003 Port CLK  input  1  rising-edge clock for all state.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port start  input  1  start/stop button level; acted on at rising edge only.
REQ-006 Port clear  input  1  user clear level; reloads count and returns to IDLE.
REQ-007 Port lap  input  1  lap button level; acted on at rising edge only.
REQ-008 Port mode  input  2  00 up-from-0, 01 up-from-ext, 10 down-from-MAX, 11 down-from-ext.
REQ-009 Port ext_value  input  WIDTH  external preload value.
REQ-010 Port tick  input  1  count-enable strobe from external prescaler.
REQ-011 Port lap_ack  input  1  consumer accepts lap_value this cycle.
REQ-012 Port count  output  WIDTH  current count.
REQ-013 Port state  output  2  IDLE=0, RUN=1, PAUSE=2, DONE=3.
REQ-014 Port done  output  1  one-cycle pulse on entry to DONE.
REQ-015 Port lap_value  output  WIDTH  captured lap count.
REQ-016 Port lap_valid  output  1  lap_value holds unconsumed capture.
REQ-017 Port lap_overrun  output  1  one-cycle pulse when a lap capture is dropped.

Function
REQ-018 Load value: mode 00 -> 0; 10 -> MAX; 01/11 -> min(ext_value, MAX).
REQ-019 Start and lap edges: registered previous level; edge = level high and previous low.
REQ-020 Per-cycle priority: reset > mode change > clear > start edge > tick; lap capture independent.
REQ-021 Mode change (mode differs from previous-cycle mode), any state -> IDLE, count <= load value of new mode.
REQ-022 IDLE: count <= load value every cycle; start edge -> RUN; tick ignored.
REQ-023 RUN: start edge -> PAUSE, count unchanged that cycle even if tick high.
REQ-024 RUN, tick, up mode: count <= count+1; if count+1 == MAX -> DONE with count MAX.
REQ-025 RUN, tick, down mode: count <= count-1; if count-1 == 0 -> DONE with count 0.
REQ-026 RUN entered with count already at terminal (up: MAX, down: 0): next cycle -> DONE, no count update, no wrap.
REQ-027 PAUSE: count held; start edge -> RUN; tick ignored.
REQ-028 DONE: count held; start edge ignored; only clear, mode change or reset leave DONE.
REQ-029 clear in RUN/PAUSE/DONE -> IDLE with load value; clear in IDLE: no effect beyond load.
REQ-030 done SHALL be high exactly the cycle after the transition into DONE is decided (registered), one cycle.
REQ-031 Lap edge in RUN or PAUSE captures count as of that cycle (pre-update) into lap_value, sets lap_valid.
REQ-032 Lap edge while lap_valid high and lap_ack low: capture dropped, lap_value kept, lap_overrun pulses.
REQ-033 lap_ack with lap_valid high clears lap_valid; simultaneous lap edge captures new value, lap_valid stays high.
REQ-034 Lap edge in IDLE or DONE ignored; lap_valid/lap_value unaffected by clear and mode change.
REQ-035 All outputs registered; no combinational input-to-output path.

Reset
REQ-036 reset: state IDLE, count <= load value of current mode, done 0, lap_valid 0, lap_value 0, lap_overrun 0.
REQ-037 reset: previous-start and previous-lap registers set to 1 (held button causes no edge); previous-mode <= mode.

Structure
REQ-038 Shared package stopwatch_pkg holds state encodings, mode encodings and counter opcode constants (HOLD, INC, DEC, LOAD).
REQ-039 Sub-module sw_counter (WIDTH, MAX) SHALL implement the count register driven by an opcode and load value.

Verification
REQ-040 Mode 00, start edge, 9999 ticks -> count 9999 on tick 9999, state DONE, done one pulse, extra ticks no change.
REQ-041 Mode 11, ext_value 12000 -> count 9999 (clamped); start, 3 ticks -> 9996; start edge with tick -> PAUSE, 9996.
REQ-042 RUN mode 00 count 42, lap edge -> lap_value 42, lap_valid 1; second lap at 50 without ack -> lap_overrun pulse, lap_value 42.
REQ-043 PAUSE at 100, mode change 00->10 -> IDLE, count 9999 next cycle; start held through reset -> no RUN.
REQ-044 Mode 10, ext ignored, DONE at 0; start edge -> stays DONE; clear -> IDLE count 9999.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state, mode and counter opcode encodings for the stopwatch
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } sw_state_t;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    INC  = 2'd1,
    DEC  = 2'd2,
    LOAD = 2'd3
  } sw_op_t;

  localparam logic [1:0] MODE_UP_ZERO = 2'b00;
  localparam logic [1:0] MODE_UP_EXT  = 2'b01;
  localparam logic [1:0] MODE_DN_MAX  = 2'b10;
  localparam logic [1:0] MODE_DN_EXT  = 2'b11;

  // Bit 1 of the mode selects the counting direction.
  function automatic logic mode_is_down(input logic [1:0] m);
    return m[1];
  endfunction

endpackage

// File: rtl/sw_counter.sv
// rtl/sw_counter.sv - count register driven by a HOLD/INC/DEC/LOAD opcode
module sw_counter
  import stopwatch_pkg::*;
#(
  parameter int WIDTH = 14,
  parameter int MAX   = 9999
) (
  input  logic             CLK,
  input  sw_op_t           op_i,
  input  logic [WIDTH-1:0] load_value_i,
  output logic [WIDTH-1:0] count_o
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);

  logic [WIDTH-1:0] count_q;

  // INC/DEC saturate at the range ends so the register can never wrap.
  always_ff @(posedge CLK) begin
    case (op_i)
      LOAD:    count_q <= load_value_i;
      INC:     if (count_q != MAX_W) count_q <= count_q + 1'b1;
      DEC:     if (count_q != '0) count_q <= count_q - 1'b1;
      default: count_q <= count_q;
    endcase
  end

  assign count_o = count_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch FSM with up/down modes, preload and single-slot lap capture
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int WIDTH = 14,
  parameter int MAX   = 9999
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic             clear,
  input  logic             lap,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] ext_value,
  input  logic             tick,
  input  logic             lap_ack,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       state,
  output logic             done,
  output logic [WIDTH-1:0] lap_value,
  output logic             lap_valid,
  output logic             lap_overrun
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);

  sw_state_t        state_q, state_d;
  sw_op_t           op;
  logic             done_q, done_d;
  logic             start_prev_q, lap_prev_q;
  logic [1:0]       mode_prev_q;
  logic [WIDTH-1:0] load_value, count_q, terminal;
  logic [WIDTH-1:0] lap_value_q;
  logic             lap_valid_q, lap_overrun_q;
  logic             start_edge, lap_edge, mode_chg, down, at_term, next_term;

  assign start_edge = start & ~start_prev_q;
  assign lap_edge   = lap & ~lap_prev_q;
  assign mode_chg   = (mode != mode_prev_q);
  assign down       = mode_is_down(mode);
  assign terminal   = down ? '0 : MAX_W;
  assign at_term    = (count_q == terminal);
  assign next_term  = down ? (count_q == WIDTH'(1)) : (count_q == MAX_W - 1'b1);

  always_comb begin
    load_value = '0;
    case (mode)
      MODE_UP_ZERO: load_value = '0;
      MODE_DN_MAX:  load_value = MAX_W;
      MODE_UP_EXT,
      MODE_DN_EXT:  load_value = (ext_value > MAX_W) ? MAX_W : ext_value;
      default:      load_value = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op      = HOLD;
    if (reset || mode_chg) begin
      state_d = IDLE;
      op      = LOAD;
    end else begin
      case (state_q)
        IDLE: begin
          op = LOAD;
          if (start_edge) state_d = RUN;
        end
        RUN: begin
          if (clear) begin
            state_d = IDLE;
            op      = LOAD;
          end else if (start_edge) begin
            state_d = PAUSE;
          end else if (at_term) begin
            state_d = DONE;
          end else if (tick) begin
            op = down ? DEC : INC;
            if (next_term) state_d = DONE;
          end
        end
        PAUSE: begin
          if (clear) begin
            state_d = IDLE;
            op      = LOAD;
          end else if (start_edge) begin
            state_d = RUN;
          end
        end
        DONE: begin
          if (clear) begin
            state_d = IDLE;
            op      = LOAD;
          end
        end
        default: begin
          state_d = IDLE;
          op      = LOAD;
        end
      endcase
    end
    done_d = (state_d == DONE) && (state_q != DONE);
  end

  sw_counter #(.WIDTH(WIDTH), .MAX(MAX)) u_counter (
    .CLK          (CLK),
    .op_i         (op),
    .load_value_i (load_value),
    .count_o      (count_q)
  );

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q      <= IDLE;
      done_q       <= 1'b0;
      start_prev_q <= 1'b1;
      lap_prev_q   <= 1'b1;
      mode_prev_q  <= mode;
    end else begin
      state_q      <= state_d;
      done_q       <= done_d;
      start_prev_q <= start;
      lap_prev_q   <= lap;
      mode_prev_q  <= mode;
    end
  end

  // Single lap slot: a new capture is only taken when the slot is free or being acked.
  always_ff @(posedge CLK) begin
    if (reset) begin
      lap_value_q   <= '0;
      lap_valid_q   <= 1'b0;
      lap_overrun_q <= 1'b0;
    end else begin
      lap_overrun_q <= 1'b0;
      if (lap_edge && (state_q == RUN || state_q == PAUSE)) begin
        if (lap_valid_q && !lap_ack) begin
          lap_overrun_q <= 1'b1;
        end else begin
          lap_value_q <= count_q;
          lap_valid_q <= 1'b1;
        end
      end else if (lap_ack) begin
        lap_valid_q <= 1'b0;
      end
    end
  end

  assign count       = count_q;
  assign state       = state_q;
  assign done        = done_q;
  assign lap_value   = lap_value_q;
  assign lap_valid   = lap_valid_q;
  assign lap_overrun = lap_overrun_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed self-checking bench for stopwatch_ctrl
module tb_stopwatch_ctrl;

  localparam int WIDTH = 14;
  localparam int MAX   = 9999;

  logic             CLK = 1'b0;
  logic             reset, start, clear, lap, tick, lap_ack;
  logic [1:0]       mode;
  logic [WIDTH-1:0] ext_value;
  logic [WIDTH-1:0] count, lap_value;
  logic [1:0]       state;
  logic             done, lap_valid, lap_overrun;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  stopwatch_ctrl #(.WIDTH(WIDTH), .MAX(MAX)) dut (
    .CLK         (CLK),
    .reset       (reset),
    .start       (start),
    .clear       (clear),
    .lap         (lap),
    .mode        (mode),
    .ext_value   (ext_value),
    .tick        (tick),
    .lap_ack     (lap_ack),
    .count       (count),
    .state       (state),
    .done        (done),
    .lap_value   (lap_value),
    .lap_valid   (lap_valid),
    .lap_overrun (lap_overrun)
  );

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1; start = 0; clear = 0; lap = 0; tick = 0; lap_ack = 0;
    mode = 2'b00; ext_value = '0;
    cyc(2);
    reset = 0;
    cyc();
    chk("rst_state", 32'(state), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_lap_valid", 32'(lap_valid), 0);
    chk("rst_lap_value", 32'(lap_value), 0);
    chk("rst_overrun", 32'(lap_overrun), 0);

    // Count up from 0 to MAX
    start = 1; cyc();
    chk("up_run", 32'(state), 1);
    chk("up_start_count", 32'(count), 0);
    start = 0; tick = 1;
    cyc(9998);
    chk("up_9998", 32'(count), 9998);
    chk("up_9998_state", 32'(state), 1);
    chk("up_9998_done", 32'(done), 0);
    cyc();
    chk("up_max", 32'(count), 9999);
    chk("up_done_state", 32'(state), 3);
    chk("up_done_pulse", 32'(done), 1);
    cyc();
    chk("up_hold", 32'(count), 9999);
    chk("up_done_once", 32'(done), 0);
    chk("up_stay_done", 32'(state), 3);

    // Down from clamped external value
    tick = 0; mode = 2'b11; ext_value = 14'd12000;
    cyc();
    chk("clamp_idle", 32'(state), 0);
    chk("clamp_count", 32'(count), 9999);
    start = 1; cyc();
    chk("dn_run", 32'(state), 1);
    start = 0; tick = 1;
    cyc(3);
    chk("dn_9996", 32'(count), 9996);
    start = 1; cyc();
    chk("pause_state", 32'(state), 2);
    chk("pause_count", 32'(count), 9996);
    start = 0; tick = 0;

    // Lap capture and overrun
    mode = 2'b00; cyc();
    chk("lap_idle_count", 32'(count), 0);
    start = 1; cyc();
    start = 0; tick = 1;
    cyc(42);
    chk("lap_pre", 32'(count), 42);
    lap = 1; cyc();
    chk("lap_value_42", 32'(lap_value), 42);
    chk("lap_valid_1", 32'(lap_valid), 1);
    chk("lap_count_43", 32'(count), 43);
    lap = 0; cyc(7);
    chk("lap_count_50", 32'(count), 50);
    lap = 1; cyc();
    chk("ovr_pulse", 32'(lap_overrun), 1);
    chk("ovr_keep", 32'(lap_value), 42);
    chk("ovr_valid", 32'(lap_valid), 1);
    lap = 0; tick = 0; cyc();
    chk("ovr_one_cycle", 32'(lap_overrun), 0);
    lap_ack = 1; cyc();
    chk("ack_clears", 32'(lap_valid), 0);
    lap_ack = 0; lap = 1; cyc();
    chk("lap_value_51", 32'(lap_value), 51);
    lap = 0; tick = 1; cyc();
    lap = 1; lap_ack = 1; tick = 0; cyc();
    chk("ack_lap_value", 32'(lap_value), 52);
    chk("ack_lap_valid", 32'(lap_valid), 1);
    chk("ack_lap_no_ovr", 32'(lap_overrun), 0);
    lap = 0; lap_ack = 0;

    // Pause at 100 then mode change; start held through reset
    tick = 1; cyc(48);
    tick = 0; start = 1; cyc();
    chk("p100_state", 32'(state), 2);
    chk("p100_count", 32'(count), 100);
    start = 0; mode = 2'b10; cyc();
    chk("mchg_state", 32'(state), 0);
    chk("mchg_count", 32'(count), 9999);
    chk("mchg_lap_kept", 32'(lap_valid), 1);
    start = 1; reset = 1; cyc();
    reset = 0; cyc(2);
    chk("held_start_idle", 32'(state), 0);
    chk("held_start_count", 32'(count), 9999);
    chk("rst_lap_clear", 32'(lap_valid), 0);

    // Down from MAX to DONE at 0; start ignored in DONE; clear reloads
    ext_value = 14'd5; start = 0; cyc();
    start = 1; cyc();
    chk("dm_run", 32'(state), 1);
    chk("dm_count", 32'(count), 9999);
    start = 0; tick = 1;
    cyc(9998);
    chk("dm_1", 32'(count), 1);
    cyc();
    chk("dm_0", 32'(count), 0);
    chk("dm_done_state", 32'(state), 3);
    chk("dm_done_pulse", 32'(done), 1);
    tick = 0; cyc();
    start = 1; lap = 1; cyc();
    chk("dm_start_ign", 32'(state), 3);
    chk("dm_hold0", 32'(count), 0);
    chk("dm_lap_ign", 32'(lap_valid), 0);
    start = 0; lap = 0; clear = 1; cyc();
    chk("clr_idle", 32'(state), 0);
    chk("clr_count", 32'(count), 9999);
    clear = 0;

    // RUN entered already at terminal goes straight to DONE
    mode = 2'b01; ext_value = 14'd12000; cyc();
    chk("term_load", 32'(count), 9999);
    start = 1; cyc();
    chk("term_run", 32'(state), 1);
    start = 0; tick = 1; cyc();
    chk("term_done", 32'(state), 3);
    chk("term_count", 32'(count), 9999);
    chk("term_pulse", 32'(done), 1);
    tick = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
